// File: rtl/tx_pkg.sv
// Shared types and defaults for the transmit scheduler and its round-robin arbiter.
package tx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        PAYLOAD  = 2'd2,
        GAP      = 2'd3
    } tx_state_t;

    localparam int          DEFAULT_PACKET_WIDTH     = 4;
    localparam logic [15:0] DEFAULT_PREAMBLE_PATTERN = 16'hAAAA;
    localparam int          PACKET_BITS              = 8 * DEFAULT_PACKET_WIDTH;

    function automatic int packet_bits(input int width);
        return 8 * width;
    endfunction

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or
// after the pointer, wrapping to the lowest index.
module rr_arbiter
    import tx_pkg::*;
#(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o
);

    logic found;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        // Upper pass: requesters at or above the pointer win.
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i] && (i >= int'(ptr_i))) begin
                grant_o[i] = 1'b1;
                found      = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i]) begin
                grant_o[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_scheduler.sv
// Transmit scheduler: grants one source round-robin, then serialises preamble and
// payload onto tx_bit, one bit per SAMPLES_PER_BIT clocks, followed by an idle gap.
module tx_scheduler
    import tx_pkg::*;
#(
    parameter int                       PACKET_WIDTH     = DEFAULT_PACKET_WIDTH,
    parameter int                       NUM_SOURCES      = 2,
    parameter int                       SAMPLES_PER_BIT  = 8,
    parameter int                       PREAMBLE_BITS    = 16,
    parameter logic [PREAMBLE_BITS-1:0] PREAMBLE_PATTERN = PREAMBLE_BITS'(DEFAULT_PREAMBLE_PATTERN),
    parameter int                       GAP_BITS         = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_SOURCES-1:0]                      src_req,
    input  logic [NUM_SOURCES-1:0][PACKET_WIDTH-1:0][7:0] src_packet,
    output logic [NUM_SOURCES-1:0]                      src_grant,
    output logic                                        tx_bit,
    output logic                                        bit_strobe,
    output logic                                        tx_active,
    output logic                                        tx_done
);

    localparam int PKT_BITS   = packet_bits(PACKET_WIDTH);
    localparam int FRAME_BITS = PREAMBLE_BITS + PKT_BITS;
    localparam int GAP_CYCLES = GAP_BITS * SAMPLES_PER_BIT;
    localparam int SMP_W      = cnt_width(SAMPLES_PER_BIT);
    localparam int BIT_W      = $clog2(FRAME_BITS + 1);
    localparam int GAP_W      = cnt_width(GAP_CYCLES);
    localparam int PTR_W      = cnt_width(NUM_SOURCES);

    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SAMPLES_PER_BIT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    tx_state_t               state_q, state_d;
    logic [SMP_W-1:0]        smp_q, smp_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [NUM_SOURCES-1:0]  grant_q, grant_d;
    logic                    tx_bit_q, tx_bit_d;
    logic                    strobe_q, strobe_d;
    logic                    active_q, active_d;
    logic                    done_q, done_d;

    logic [NUM_SOURCES-1:0]             arb_grant;
    logic [PTR_W-1:0]                   grant_idx;
    logic [PTR_W-1:0]                   next_ptr;
    logic [PACKET_WIDTH-1:0][7:0]       sel_packet;
    logic [FRAME_BITS-1:0]              frame_w;

    rr_arbiter #(
        .N     (NUM_SOURCES),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i   (src_req),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant)
    );

    always_comb begin
        grant_idx  = '0;
        sel_packet = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (arb_grant[i]) begin
                grant_idx  = PTR_W'(i);
                sel_packet = src_packet[i];
            end
        end
        next_ptr = (grant_idx == PTR_W'(NUM_SOURCES - 1)) ? '0 : grant_idx + PTR_W'(1);
    end

    // Whole frame MSB-first: preamble, then byte 0 .. byte PACKET_WIDTH-1.
    always_comb begin
        frame_w = '0;
        frame_w[FRAME_BITS-1 -: PREAMBLE_BITS] = PREAMBLE_PATTERN;
        for (int b = 0; b < PACKET_WIDTH; b++) begin
            frame_w[PKT_BITS-1-8*b -: 8] = sel_packet[b];
        end
    end

    always_comb begin
        state_d  = state_q;
        smp_d    = smp_q;
        bit_d    = bit_q;
        gap_d    = gap_q;
        shift_d  = shift_q;
        ptr_d    = ptr_q;
        grant_d  = '0;
        tx_bit_d = tx_bit_q;
        strobe_d = 1'b0;
        active_d = active_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|src_req) begin
                    state_d  = PREAMBLE;
                    grant_d  = arb_grant;
                    ptr_d    = next_ptr;
                    tx_bit_d = frame_w[FRAME_BITS-1];
                    shift_d  = frame_w << 1;
                    strobe_d = 1'b1;
                    active_d = 1'b1;
                    smp_d    = '0;
                    bit_d    = '0;
                end
            end
            PREAMBLE, PAYLOAD: begin
                if (smp_q == SMP_LAST) begin
                    smp_d = '0;
                    if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
                        state_d  = (GAP_CYCLES == 0) ? IDLE : GAP;
                        gap_d    = '0;
                        tx_bit_d = 1'b0;
                        active_d = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        bit_d    = bit_q + BIT_W'(1);
                        tx_bit_d = shift_q[FRAME_BITS-1];
                        shift_d  = shift_q << 1;
                        strobe_d = 1'b1;
                        if (bit_q == BIT_W'(PREAMBLE_BITS - 1)) begin
                            state_d = PAYLOAD;
                        end
                    end
                end else begin
                    smp_d = smp_q + SMP_W'(1);
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            smp_q    <= '0;
            bit_q    <= '0;
            gap_q    <= '0;
            shift_q  <= '0;
            ptr_q    <= '0;
            grant_q  <= '0;
            tx_bit_q <= 1'b0;
            strobe_q <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            smp_q    <= smp_d;
            bit_q    <= bit_d;
            gap_q    <= gap_d;
            shift_q  <= shift_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            tx_bit_q <= tx_bit_d;
            strobe_q <= strobe_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign src_grant  = grant_q;
    assign tx_bit     = tx_bit_q;
    assign bit_strobe = strobe_q;
    assign tx_active  = active_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Scoreboard bench for tx_scheduler: a frame-level model predicts grants, a monitor
// checks each granted frame's line waveform, strobes, activity and done pulse.
module tb_tx_scheduler;

    localparam int PW     = 2;
    localparam int NS     = 2;
    localparam int SPB    = 4;
    localparam int PRE    = 8;
    localparam int GAPB   = 2;
    localparam int NBITS  = PRE + 8 * PW;
    localparam int F      = NBITS * SPB;
    localparam int PERIOD = F + GAPB * SPB + 1;

    logic                      clk;
    logic                      rst;
    logic [NS-1:0]             src_req;
    logic [NS-1:0][PW-1:0][7:0] src_packet;
    logic [NS-1:0]             src_grant;
    logic                      tx_bit, bit_strobe, tx_active, tx_done;

    logic [NS-1:0]             req1;
    logic [NS-1:0][PW-1:0][7:0] pkt1;
    logic [NS-1:0]             grant1;
    logic                      tx_bit1, strobe1, active1, done1;

    tx_scheduler #(
        .PACKET_WIDTH(PW), .NUM_SOURCES(NS), .SAMPLES_PER_BIT(SPB),
        .PREAMBLE_BITS(PRE), .PREAMBLE_PATTERN(8'hAA), .GAP_BITS(GAPB)
    ) dut (
        .clk(clk), .rst(rst), .src_req(src_req), .src_packet(src_packet),
        .src_grant(src_grant), .tx_bit(tx_bit), .bit_strobe(bit_strobe),
        .tx_active(tx_active), .tx_done(tx_done)
    );

    tx_scheduler #(
        .PACKET_WIDTH(PW), .NUM_SOURCES(NS), .SAMPLES_PER_BIT(1),
        .PREAMBLE_BITS(PRE), .PREAMBLE_PATTERN(8'hAA), .GAP_BITS(GAPB)
    ) dut_spb1 (
        .clk(clk), .rst(rst), .src_req(req1), .src_packet(pkt1),
        .src_grant(grant1), .tx_bit(tx_bit1), .bit_strobe(strobe1),
        .tx_active(active1), .tx_done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int                  src;
        logic [PW-1:0][7:0]  pkt;
        int                  edge_no;
    } exp_t;

    exp_t exp_q[$];
    int   edge_cnt     = 0;
    int   m_ptr        = 0;
    int   m_free       = 0;
    int   frames_done  = 0;
    int   frames_abort = 0;
    int   frames_pred  = 0;
    int   quiet_err    = 0;

    // Reference model: one frame occupies the scheduler for PERIOD edges; grants
    // go to the first requester at or after the pointer.
    initial begin
        forever begin
            @(posedge clk);
            edge_cnt++;
            if (rst) begin
                m_ptr  = 0;
                m_free = edge_cnt + 1;
            end else if (edge_cnt >= m_free && |src_req) begin
                int g;
                g = -1;
                for (int k = 0; k < NS; k++) begin
                    int idx;
                    idx = (m_ptr + k) % NS;
                    if (g < 0 && src_req[idx]) g = idx;
                end
                exp_q.push_back('{src: g, pkt: src_packet[g], edge_no: edge_cnt});
                frames_pred++;
                m_ptr  = (g + 1) % NS;
                m_free = edge_cnt + PERIOD;
            end
        end
    end

    // Monitor: samples just after each rising edge.
    initial begin
        logic [7:0] pre;
        pre = 8'hAA;
        forever begin
            @(posedge clk); #1;
            if (rst) continue;
            if (src_grant != '0) begin
                check("grant_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    logic [NBITS-1:0] fb;
                    int bit_mis, stb_mis, act_mis, done_mis, gnt_mis;
                    bit aborted;
                    e  = exp_q.pop_front();
                    fb = {pre, e.pkt[0], e.pkt[1]};
                    check("grant_vec", 64'(src_grant), 64'd1 << e.src);
                    check("grant_time", 64'(edge_cnt), 64'(e.edge_no));
                    bit_mis = 0; stb_mis = 0; act_mis = 0; done_mis = 0; gnt_mis = 0;
                    aborted = 1'b0;
                    for (int c = 0; c <= F; c++) begin
                        if (c > 0) begin
                            @(posedge clk); #1;
                        end
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (c < F) begin
                            if (tx_bit !== fb[NBITS-1-c/SPB]) bit_mis++;
                            if (bit_strobe !== (c % SPB == 0)) stb_mis++;
                            if (tx_active !== 1'b1) act_mis++;
                            if (tx_done !== 1'b0) done_mis++;
                            if (c > 0 && src_grant !== '0) gnt_mis++;
                        end else begin
                            if (tx_bit !== 1'b0) bit_mis++;
                            if (bit_strobe !== 1'b0) stb_mis++;
                            if (tx_active !== 1'b0) act_mis++;
                            if (tx_done !== 1'b1) done_mis++;
                            if (src_grant !== '0) gnt_mis++;
                        end
                    end
                    if (aborted) begin
                        frames_abort++;
                    end else begin
                        frames_done++;
                        check("frame_line_bits", 64'(bit_mis), 64'd0);
                        check("frame_strobes", 64'(stb_mis), 64'd0);
                        check("frame_active", 64'(act_mis), 64'd0);
                        check("frame_done_pulse", 64'(done_mis), 64'd0);
                        check("frame_grant_pulse", 64'(gnt_mis), 64'd0);
                    end
                end
            end else if (tx_active || bit_strobe || tx_done || tx_bit) begin
                quiet_err++;
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_grant(input int src);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (src_grant[src]) begin
                ok = 1'b1;
                break;
            end
        end
        check($sformatf("grant_arrives_src%0d", src), 64'(ok), 64'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_grant"},  64'(src_grant),  64'd0);
        check({tag, "_tx_bit"}, 64'(tx_bit),     64'd0);
        check({tag, "_strobe"}, 64'(bit_strobe), 64'd0);
        check({tag, "_active"}, 64'(tx_active),  64'd0);
        check({tag, "_done"},   64'(tx_done),    64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        src_req    = '0;
        src_packet = '0;
        req1       = '0;
        pkt1       = '0;
        wait_cycles(3);
        check_outputs_zero("reset");
        rst = 1'b0;
        wait_cycles(2);

        // Single frame from src0.
        src_packet[0][0] = 8'h3C;
        src_packet[0][1] = 8'hA5;
        src_req = 2'b01;
        wait_grant(0);
        src_req = '0;
        wait_cycles(PERIOD + 5);

        // Simultaneous requests right after reset.
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        src_packet[0] = {8'h11, 8'h22};
        src_packet[1] = {8'h5A, 8'hC3};
        src_req = 2'b11;
        wait_grant(0);
        src_req[0] = 1'b0;
        wait_grant(1);
        src_req = '0;
        wait_cycles(PERIOD + 5);

        // Both requesters held for four frames.
        src_req = 2'b11;
        wait_cycles(4 * PERIOD + 5);
        src_req = '0;
        wait_cycles(PERIOD + 5);

        // src1 arrives mid-frame.
        src_packet[0] = {8'hF0, 8'h0F};
        src_req = 2'b01;
        wait_grant(0);
        src_req = '0;
        wait_cycles(10);
        src_packet[1] = {8'h81, 8'h7E};
        src_req = 2'b10;
        wait_grant(1);
        src_req = '0;
        wait_cycles(PERIOD + 5);

        // Reset in the middle of a frame.
        src_req = 2'b01;
        wait_grant(0);
        src_req = '0;
        wait_cycles(39);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("midreset");
        rst = 1'b0;
        src_req = 2'b11;
        wait_grant(0);
        src_req[0] = 1'b0;
        wait_grant(1);
        src_req = '0;
        wait_cycles(PERIOD + 5);

        // Random traffic; a request is held until its grant, then sometimes kept.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < NS; i++) begin
                if (src_req[i] && src_grant[i]) begin
                    src_req[i] = ($urandom_range(0, 3) == 0);
                end else if (!src_req[i] && $urandom_range(0, 19) == 0) begin
                    src_packet[i] = {8'($urandom), 8'($urandom)};
                    src_req[i]    = 1'b1;
                end
            end
        end
        src_req = '0;
        wait_cycles(PERIOD + 5);

        // One sample per bit: strobe on every frame cycle, done after 24 cycles.
        begin
            logic [NBITS-1:0] fb1;
            bit ok;
            int strobes, bit_mis, act_mis, done_mis;
            fb1 = {8'hAA, 8'h3C, 8'hA5};
            pkt1[0][0] = 8'h3C;
            pkt1[0][1] = 8'hA5;
            req1 = 2'b01;
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (grant1 != '0) begin
                    ok = 1'b1;
                    break;
                end
            end
            req1 = '0;
            check("spb1_grant_arrives", 64'(ok), 64'd1);
            if (ok) begin
                check("spb1_grant_vec", 64'(grant1), 64'd1);
                strobes = 0; bit_mis = 0; act_mis = 0; done_mis = 0;
                for (int c = 0; c < NBITS; c++) begin
                    if (c > 0) @(negedge clk);
                    if (strobe1 && active1) strobes++;
                    if (tx_bit1 !== fb1[NBITS-1-c]) bit_mis++;
                    if (active1 !== 1'b1) act_mis++;
                    if (done1 !== 1'b0) done_mis++;
                end
                check("spb1_strobes", 64'(strobes), 64'(NBITS));
                check("spb1_line_bits", 64'(bit_mis), 64'd0);
                check("spb1_active", 64'(act_mis), 64'd0);
                check("spb1_early_done", 64'(done_mis), 64'd0);
                @(negedge clk);
                check("spb1_done", 64'(done1), 64'd1);
                check("spb1_active_end", 64'(active1), 64'd0);
                check("spb1_strobe_end", 64'(strobe1), 64'd0);
            end
            wait_cycles(20);
        end

        check("pending_expected_grants", 64'(exp_q.size()), 64'd0);
        check("frames_accounted", 64'(frames_done + frames_abort), 64'(frames_pred));
        check("idle_outputs_quiet", 64'(quiet_err), 64'd0);
        check("reset_aborted_frames", 64'(frames_abort), 64'd1);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/tx_scheduler.md
# tx_scheduler

Transmit-side controller for the BPSK transmitter. It arbitrates round-robin between `NUM_SOURCES` packet producers and captures the granted `PACKET_WIDTH`-byte packet. It then sequences one frame (a fixed preamble followed by the payload) onto a single bit line, with one bit held per `SAMPLES_PER_BIT` clocks and a strobe for the modulator. It sits between the system packet sources and the modulator/symbol mapper.

## Interface
Parameters:
- `PACKET_WIDTH`, default from the shared parameters header: payload length in bytes.
- `NUM_SOURCES`, default 2: number of requesters; must be ≥1.
- `SAMPLES_PER_BIT`, default 8: clocks per transmitted bit; must be ≥1.
- `PREAMBLE_BITS`, default 16: preamble length.
- `PREAMBLE_PATTERN`, default 16'hAAAA: preamble, sent MSB first.
- `GAP_BITS`, default 4: idle bit periods after each frame.

Ports:
- `clk`  in  1  sole clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `src_req`  in  `NUM_SOURCES`  per-source request level.
- `src_packet`  in  `[NUM_SOURCES-1:0][PACKET_WIDTH-1:0][7:0]`  per-source packet; byte 0 is sent first.
- `src_grant`  out  `NUM_SOURCES`  one-hot, 1-cycle pulse; the packet is captured on that edge.
- `tx_bit`  out  1  current line bit.
- `bit_strobe`  out  1  high on the first clock of every bit period.
- `tx_active`  out  1  high for the entire frame (preamble and payload).
- `tx_done`  out  1  1-cycle pulse on the first GAP cycle.

## Operation
- States: `IDLE`, `PREAMBLE`, `PAYLOAD`, `GAP`.
- **IDLE**
  - If any `src_req` is high, grant the first requester at or after `rr_ptr`, scanning upward with wrap.
  - Capture that source's packet into the shift register.
  - Set `rr_ptr` to grantee+1 (mod `NUM_SOURCES`).
  - Go to `PREAMBLE`.
- **PREAMBLE**
  - Send `PREAMBLE_PATTERN[PREAMBLE_BITS-1]` down to bit 0.
- **PAYLOAD**
  - Send bytes 0 to `PACKET_WIDTH-1`, each MSB first.
- **GAP**
  - Hold for `GAP_BITS*SAMPLES_PER_BIT` cycles.
  - Outputs during GAP: `tx_active=0`, `tx_bit=0`, no strobes.
  - Then go to `IDLE`.
- Requests:
  - Requests arriving outside `IDLE` are held off; there is no mid-frame grant and no preemption.
  - A source must hold `src_req` and `src_packet` stable until it sees its grant.
  - A `src_req` still high on the cycle after its grant counts as a new request.
- Counters:
  - Sample counter is `$clog2(SAMPLES_PER_BIT)` bits wide, or 1 bit if `SAMPLES_PER_BIT==1`.
  - Bit counter is `$clog2(PREAMBLE_BITS+8*PACKET_WIDTH+1)` bits wide.
  - Neither counter may wrap inside a state.
- Reset, including mid-frame:
  - All outputs go to 0 and the state goes to `IDLE`.
  - `rr_ptr` goes to 0.
  - The in-flight packet is dropped and not re-granted.

## Timing
- Reset values: `src_grant=0`, `tx_bit=0`, `bit_strobe=0`, `tx_active=0`, `tx_done=0`, `rr_ptr=0`. All outputs are registered.
- Grant:
  - A request sampled in `IDLE` at edge k produces `src_grant` high during cycle G=k+1.
  - In cycle G: `tx_active=1`, `bit_strobe=1`, and `tx_bit` is the first preamble bit.
- Frame length: F=(`PREAMBLE_BITS`+8·`PACKET_WIDTH`)·`SAMPLES_PER_BIT` cycles.
  - `tx_active` is high for cycles G..G+F-1.
  - Bit n is driven during cycles G+n·SPB .. G+(n+1)·SPB-1.
- GAP and return to IDLE:
  - `tx_done` is high in cycle G+F.
  - `IDLE` is entered at G+F+`GAP_BITS`·SPB.
  - The earliest next grant is one cycle later.
- `SAMPLES_PER_BIT=1`: `bit_strobe` is high on every frame cycle.
- Simultaneous requests: resolved purely by `rr_ptr`.

## Structure
- Package `tx_pkg`: state enum `tx_state_t`, default `PREAMBLE_PATTERN`, and a `PACKET_BITS = 8*PACKET_WIDTH` constant.
- Sub-module `rr_arbiter`:
  - Inputs: request vector and pointer.
  - Output: one-hot grant, combinational.
  - `tx_scheduler` registers the grant and updates the pointer.

## Test plan
Common configuration: `PACKET_WIDTH=2`, `NUM_SOURCES=2`, `SAMPLES_PER_BIT=4`, `PREAMBLE_BITS=8`, `PREAMBLE_PATTERN=8'hAA`, `GAP_BITS=2`, so F=96.

- **Single frame:** src0 requests with bytes {0x3C, 0xA5}.
  - `src_grant=01` at G.
  - `tx_bit` sequence is 10101010 00111100 10100101, each bit held 4 cycles, with strobes at G+4n.
  - `tx_done` at G+96; next grant possible at G+105.
- **Simultaneous requests after reset:** src0 is granted first; src1 is granted at G+105.
- **Both requesters held continuously:** grants alternate 01, 10, 01, 10 with frame spacing 105.
- **src1 requests at G+10 during src0's frame:** no grant until `IDLE`; `src_grant=10` at G+105.
- **`rst` at cycle G+40:**
  - Next cycle: all outputs 0.
  - Both then request: src0 is granted (`rr_ptr` reset to 0).
- **`SAMPLES_PER_BIT=1` variant:** `bit_strobe` high on all 24 frame cycles; `tx_done` at G+24.
